updown_mod_counter: RTL and testbench



---
 rtl/updown_mod_counter_pkg.sv | 19 +
 rtl/updown_mod_counter_next.sv | 44 ++++
 rtl/updown_mod_counter.sv | 111 +++++++++++
 tb/tb_updown_mod_counter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/updown_mod_counter_pkg.sv
// Shared types and defaults for the up/down modulo counter.
// Included by the counter shell and its next-count logic.
package updown_mod_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_STOPPED = 1'b1
    } state_e;

endpackage

// File: rtl/updown_mod_counter_next.sv
// Combinational next-count logic for one ce step of the up/down modulo counter.
// Also usable on its own as a golden reference for the counting rules.
module updown_mod_counter_next
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] max_val,
    input  logic             up_down,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_count,
    output logic             hit_bound,
    output logic             at_bound
);

    logic [WIDTH-1:0] bound;
    logic [WIDTH-1:0] stepped;

    // A count above max_val (bound lowered mid-run) is treated as sitting at the upper bound.
    always_comb begin
        bound      = up_down ? max_val : '0;
        at_bound   = up_down ? (count >= max_val) : (count == '0);
        stepped    = up_down ? (count + 1'b1) : (count - 1'b1);
        next_count = stepped;
        hit_bound  = 1'b0;
        case (mode_e'(mode))
            MODE_SAT, MODE_ONESHOT: begin
                next_count = at_bound ? bound : stepped;
                hit_bound  = (next_count == bound) && (count != bound);
            end
            default: begin
                if (at_bound) begin
                    next_count = up_down ? '0 : max_val;
                    hit_bound  = 1'b1;
                end else begin
                    next_count = stepped;
                    hit_bound  = (stepped == bound);
                end
            end
        endcase
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter with programmable bound and WRAP / SAT / ONESHOT end-of-range modes.
// Define UPDOWN_MOD_COUNTER_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_n,
    input  logic [WIDTH-1:0] data_load,
    input  logic             ce,
    input  logic             up_down,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count_out,
    output logic             max_count,
    output logic             zero,
    output logic             tc,
    output logic             done,
    output logic             ovf
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    state_e           state_q, state_d;

    logic [WIDTH-1:0] next_count;
    logic             hit_bound;
    logic             at_bound;
    logic             step_en;

    updown_mod_counter_next #(.WIDTH(WIDTH)) u_next (
        .count      (count_q),
        .max_val    (max_val),
        .up_down    (up_down),
        .mode       (mode),
        .next_count (next_count),
        .hit_bound  (hit_bound),
        .at_bound   (at_bound)
    );

    assign step_en = load_n && ce && (state_q == ST_RUN);

    // Load beats counting; a STOPPED counter only leaves via load, reset or a mode change.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        state_d = state_q;
        if (!load_n) begin
            count_d = (data_load > max_val) ? max_val : data_load;
            state_d = ST_RUN;
        end else if (state_q == ST_STOPPED) begin
            if (mode_e'(mode) != MODE_ONESHOT) begin
                state_d = ST_RUN;
            end
        end else if (ce) begin
            count_d = next_count;
            tc_d    = hit_bound;
            if ((mode_e'(mode) == MODE_ONESHOT) && (hit_bound || at_bound)) begin
                state_d = ST_STOPPED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            state_q <= state_d;
        end
    end

`ifdef UPDOWN_MOD_COUNTER_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (!load_n) begin
            ovf_d = 1'b0;
        end else if (step_en && at_bound) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_step;
    assign unused_step = step_en;
    assign ovf         = 1'b0;
`endif

    assign count_out = count_q;
    assign tc        = tc_q;
    assign done      = (state_q == ST_STOPPED);
    assign max_count = (count_q == max_val);
    assign zero      = (count_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed self-checking bench for updown_mod_counter (WIDTH=4).
// Expected ovf follows UPDOWN_MOD_COUNTER_OVF_EN when the bench is built with it.
module tb_updown_mod_counter;

    localparam int W = 4;

`ifdef UPDOWN_MOD_COUNTER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_n;
    logic [W-1:0] data_load;
    logic         ce;
    logic         up_down;
    logic [1:0]   mode;
    logic [W-1:0] max_val;
    logic [W-1:0] count_out;
    logic         max_count;
    logic         zero;
    logic         tc;
    logic         done;
    logic         ovf;

    int n_checks = 0;
    int n_fails  = 0;

    updown_mod_counter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_n    (load_n),
        .data_load (data_load),
        .ce        (ce),
        .up_down   (up_down),
        .mode      (mode),
        .max_val   (max_val),
        .count_out (count_out),
        .max_count (max_count),
        .zero      (zero),
        .tc        (tc),
        .done      (done),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] value);
        load_n    = 1'b0;
        data_load = value;
        tick();
        load_n    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_n = 1'b1; data_load = '0; ce = 1'b1;
        up_down = 1'b1; mode = 2'b00; max_val = 4'd9;
        tick(); tick();
        n_checks++;
        if ({count_out, tc, zero, done, ovf, max_count} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fails++;
            $display("[TB] FAIL reset: count=%0d tc=%b zero=%b done=%b ovf=%b max=%b, want 0 0 1 0 0 0",
                     count_out, tc, zero, done, ovf, max_count);
        end
    endtask

    task automatic test_wrap();
        int exp_c [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        bit exp_t [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (count_out !== W'(exp_c[i]) || tc !== exp_t[i] || zero !== (exp_c[i] == 0)) begin
                n_fails++;
                $display("[TB] FAIL wrap_up[%0d]: count=%0d tc=%b zero=%b, want %0d %b %b",
                         i, count_out, tc, zero, exp_c[i], exp_t[i], exp_c[i] == 0);
            end
        end
    endtask

    task automatic test_sat();
        int exp_c [6] = '{2, 1, 0, 0, 0, 0};
        bit exp_t [6] = '{0, 0, 1, 0, 0, 0};
        bit exp_o [6] = '{0, 0, 0, 1, 1, 1};
        mode = 2'b01; max_val = 4'd5; ce = 1'b0;
        do_load(4'd3);
        n_checks++;
        if (count_out !== 4'd3 || tc !== 1'b0 || ovf !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL sat_load: count=%0d tc=%b ovf=%b, want 3 0 0", count_out, tc, ovf);
        end
        up_down = 1'b0; ce = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (count_out !== W'(exp_c[i]) || tc !== exp_t[i] || ovf !== (exp_o[i] & OVF_ON)) begin
                n_fails++;
                $display("[TB] FAIL sat_down[%0d]: count=%0d tc=%b ovf=%b, want %0d %b %b",
                         i, count_out, tc, ovf, exp_c[i], exp_t[i], exp_o[i] & OVF_ON);
            end
        end
    endtask

    task automatic test_oneshot();
        int exp_c [6] = '{5, 6, 7, 7, 7, 7};
        bit exp_t [6] = '{0, 0, 1, 0, 0, 0};
        bit exp_d [6] = '{0, 0, 1, 1, 1, 1};
        mode = 2'b10; max_val = 4'd7; up_down = 1'b1; ce = 1'b0;
        do_load(4'd4);
        ce = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (count_out !== W'(exp_c[i]) || tc !== exp_t[i] || done !== exp_d[i] || ovf !== 1'b0) begin
                n_fails++;
                $display("[TB] FAIL oneshot[%0d]: count=%0d tc=%b done=%b ovf=%b, want %0d %b %b 0",
                         i, count_out, tc, done, ovf, exp_c[i], exp_t[i], exp_d[i]);
            end
        end
        do_load(4'd2);
        n_checks++;
        if (count_out !== 4'd2 || done !== 1'b0 || tc !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL oneshot_rearm: count=%0d done=%b tc=%b, want 2 0 0", count_out, done, tc);
        end
    endtask

    task automatic test_load_clamp();
        mode = 2'b00; max_val = 4'd10; up_down = 1'b1; ce = 1'b1;
        do_load(4'd14);
        n_checks++;
        if (count_out !== 4'd10 || max_count !== 1'b1 || tc !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL load_clamp: count=%0d max=%b tc=%b, want 10 1 0", count_out, max_count, tc);
        end
    endtask

    task automatic test_wrap_lowered();
        max_val = 4'd15; ce = 1'b0;
        do_load(4'd12);
        max_val = 4'd8; ce = 1'b1; up_down = 1'b1;
        tick();
        n_checks++;
        if (count_out !== 4'd0 || tc !== 1'b1 || ovf !== OVF_ON) begin
            n_fails++;
            $display("[TB] FAIL wrap_lowered_up: count=%0d tc=%b ovf=%b, want 0 1 %b", count_out, tc, ovf, OVF_ON);
        end
        up_down = 1'b0;
        tick();
        n_checks++;
        if (count_out !== 4'd8 || tc !== 1'b1 || max_count !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL wrap_down_from_zero: count=%0d tc=%b max=%b, want 8 1 1", count_out, tc, max_count);
        end
    endtask

    task automatic test_degenerate();
        mode = 2'b11; max_val = 4'd0; ce = 1'b0; up_down = 1'b1;
        do_load(4'd6);
        ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_down = (i != 1);
            tick();
            n_checks++;
            if (count_out !== 4'd0 || tc !== 1'b1 || max_count !== 1'b1 || zero !== 1'b1) begin
                n_fails++;
                $display("[TB] FAIL max_zero[%0d]: count=%0d tc=%b max=%b zero=%b, want 0 1 1 1",
                         i, count_out, tc, max_count, zero);
            end
        end
    endtask

    task automatic test_stopped_exit();
        mode = 2'b10; max_val = 4'd7; up_down = 1'b1; ce = 1'b0;
        do_load(4'd6);
        ce = 1'b1;
        tick();
        mode = 2'b00;
        tick();
        n_checks++;
        if (count_out !== 4'd7 || done !== 1'b0 || tc !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL stop_exit: count=%0d done=%b tc=%b, want 7 0 0", count_out, done, tc);
        end
        tick();
        n_checks++;
        if (count_out !== 4'd0 || tc !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL stop_exit_step: count=%0d tc=%b, want 0 1", count_out, tc);
        end
    endtask

    task automatic test_reset_stopped();
        mode = 2'b10; max_val = 4'd7; up_down = 1'b1; ce = 1'b0;
        do_load(4'd5);
        ce = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (count_out !== 4'd7 || done !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL pre_reset_stopped: count=%0d done=%b, want 7 1", count_out, done);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (count_out !== 4'd0 || done !== 1'b0 || tc !== 1'b0 || zero !== 1'b1 || ovf !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_stopped: count=%0d done=%b tc=%b zero=%b ovf=%b, want 0 0 0 1 0",
                     count_out, done, tc, zero, ovf);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_sat();
        test_oneshot();
        test_load_clamp();
        test_wrap_lowered();
        test_degenerate();
        test_stopped_exit();
        test_reset_stopped();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
